// File: rtl/store_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Package : mem_pkg
// Purpose : Shared memory-access definitions for the store buffer and the
//           data RAM: func3 encodings, access-size decode, the store-buffer
//           entry record and load result extension.
// Revision: 1.0 - initial release
// ============================================================================
package mem_pkg;

  localparam int MEM_WA = 32;
  localparam int MEM_WD = 32;

  // Store encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;
  // Load encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef struct packed {
    logic [MEM_WA-1:0] addr;
    logic [2:0]        func3;
    logic [MEM_WD-1:0] data;
  } sb_entry_t;

  // Access size in bytes from the low two func3 bits (bit 2 only selects
  // signedness and never changes the size).
  function automatic logic [2:0] size_bytes(input logic [1:0] size_sel);
    case (size_sel)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Extend the low bytes of a raw value according to the load type.
  function automatic logic [MEM_WD-1:0] load_extend(input logic [2:0]        f3,
                                                    input logic [MEM_WD-1:0] raw);
    case (f3)
      F3_LB:   return {{(MEM_WD-8){raw[7]}}, raw[7:0]};
      F3_LH:   return {{(MEM_WD-16){raw[15]}}, raw[15:0]};
      F3_LBU:  return {{(MEM_WD-8){1'b0}}, raw[7:0]};
      F3_LHU:  return {{(MEM_WD-16){1'b0}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/store_buffer_cmp.sv
`default_nettype none
// ============================================================================
// Module  : store_buffer_cmp
// Purpose : Combinational comparison of one buffered store against the
//           current load: byte-range overlap and (with STORE_FWD_EN) exact
//           address/size match.
// Ports   : ent_valid      - entry holds a pending store
//           ent_addr       - entry byte address
//           ent_size_sel   - entry func3[1:0]
//           ld_addr        - load byte address
//           ld_size_sel    - load func3[1:0]
//           overlap        - valid entry shares at least one byte with load
//           exact          - valid entry has same address and size (only
//                            present when STORE_FWD_EN is defined)
// Revision: 1.0 - initial release
// ============================================================================
module store_buffer_cmp
  import mem_pkg::*;
#(
  parameter int WA = 32
) (
  input  logic          ent_valid,
  input  logic [WA-1:0] ent_addr,
  input  logic [1:0]    ent_size_sel,
  input  logic [WA-1:0] ld_addr,
  input  logic [1:0]    ld_size_sel,
  output logic          overlap
`ifdef STORE_FWD_EN
  ,
  output logic          exact
`endif
);

  logic [2:0]  w_ent_size;
  logic [2:0]  w_ld_size;
  logic [WA:0] w_ent_start;
  logic [WA:0] w_ent_end;
  logic [WA:0] w_ld_start;
  logic [WA:0] w_ld_end;

  assign w_ent_size = size_bytes(ent_size_sel);
  assign w_ld_size  = size_bytes(ld_size_sel);

  // One extra bit keeps ranges near the top of the address space from
  // wrapping back to zero.
  assign w_ent_start = {1'b0, ent_addr};
  assign w_ld_start  = {1'b0, ld_addr};
  assign w_ent_end   = w_ent_start + (WA+1)'(w_ent_size) - (WA+1)'(1);
  assign w_ld_end    = w_ld_start + (WA+1)'(w_ld_size) - (WA+1)'(1);

  assign overlap = ent_valid && (w_ld_start <= w_ent_end) && (w_ent_start <= w_ld_end);

`ifdef STORE_FWD_EN
  assign exact = ent_valid && (ent_addr == ld_addr) && (w_ent_size == w_ld_size);
`endif

endmodule : store_buffer_cmp
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// Module  : store_buffer
// Purpose : DEPTH-entry FIFO write buffer between the memory stage and the
//           byte-addressed data RAM. Stores retire into the buffer and drain
//           to the RAM whenever no load is using the port. Loads overlapping
//           a pending store stall until the overlapping stores have drained.
//           Optional macro STORE_FWD_EN: a load whose youngest overlapping
//           store has identical address and size is served from the buffer.
// Ports   : clk, rst_n                        - clock, async active-low reset
//           StReq/StReady/StAd/StFunc3/StData - store enqueue interface
//           LdReq/LdAd/LdFunc3/LdData/LdStall - load interface
//           BufEmpty                          - no pending stores
//           Ad/RamWrite/func3/DIn/DOut        - RAM request port
// Revision: 1.0 - initial release
// ============================================================================
module store_buffer
  import mem_pkg::*;
#(
  parameter int WA    = 32,
  parameter int WD    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          StReq,
  output logic          StReady,
  input  logic [WA-1:0] StAd,
  input  logic [2:0]    StFunc3,
  input  logic [WD-1:0] StData,
  input  logic          LdReq,
  input  logic [WA-1:0] LdAd,
  input  logic [2:0]    LdFunc3,
  output logic [WD-1:0] LdData,
  output logic          LdStall,
  output logic          BufEmpty,
  output logic [WA-1:0] Ad,
  output logic          RamWrite,
  output logic [2:0]    func3,
  output logic [WD-1:0] DIn,
  input  logic [WD-1:0] DOut
);

  localparam int         PW      = $clog2(DEPTH);
  localparam logic [PW:0] C_DEPTH = (PW+1)'(DEPTH);

  sb_entry_t      mem_q [DEPTH];
  logic [PW-1:0]  head_q, head_d;
  logic [PW-1:0]  tail_q, tail_d;
  logic [PW:0]    count_q, count_d;

  logic [DEPTH-1:0] overlap;
  logic             enq;
  logic             drain;
  logic             ld_fwd;
  logic             ld_ram;
  sb_entry_t        head_ent;

  // --------------------------------------------------------------------------
  // Per-slot hazard comparison. A slot is valid when its distance from head
  // is below the occupancy count.
  // --------------------------------------------------------------------------
`ifdef STORE_FWD_EN
  logic [DEPTH-1:0] exact;
`endif

  for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
    logic [PW-1:0] age;
    logic          ent_valid;

    assign age       = PW'(i) - head_q;
    assign ent_valid = ({1'b0, age} < count_q);

    store_buffer_cmp #(
      .WA (WA)
    ) u_cmp (
      .ent_valid    (ent_valid),
      .ent_addr     (mem_q[i].addr),
      .ent_size_sel (mem_q[i].func3[1:0]),
      .ld_addr      (LdAd),
      .ld_size_sel  (LdFunc3[1:0]),
      .overlap      (overlap[i])
`ifdef STORE_FWD_EN
      ,
      .exact        (exact[i])
`endif
    );
  end

  // --------------------------------------------------------------------------
  // Forwarding: only the youngest overlapping store may supply the data, and
  // only when it covers exactly the bytes the load asks for.
  // --------------------------------------------------------------------------
`ifdef STORE_FWD_EN
  logic [PW-1:0] y_idx;
  logic          y_found;

  always_comb begin
    y_idx   = head_q;
    y_found = 1'b0;
    // Walk oldest to youngest so the last hit is the youngest.
    for (int k = 0; k < DEPTH; k++) begin
      if (overlap[head_q + PW'(k)]) begin
        y_idx   = head_q + PW'(k);
        y_found = 1'b1;
      end
    end
  end

  assign ld_fwd = y_found && exact[y_idx];
  assign LdData = ld_fwd ? load_extend(LdFunc3, mem_q[y_idx].data) : DOut;
`else
  assign ld_fwd = 1'b0;
  assign LdData = DOut;
`endif

  // --------------------------------------------------------------------------
  // RAM port arbitration: an unstalled RAM load owns the port, otherwise the
  // head entry drains. A forwarded load does not need the port.
  // --------------------------------------------------------------------------
  assign LdStall  = LdReq && (|overlap) && !ld_fwd;
  assign ld_ram   = LdReq && !LdStall && !ld_fwd;
  assign drain    = !ld_ram && (count_q != '0);
  assign head_ent = mem_q[head_q];

  assign RamWrite = drain;
  assign Ad       = drain ? head_ent.addr  : LdAd;
  assign func3    = drain ? head_ent.func3 : LdFunc3;
  assign DIn      = head_ent.data;

  assign StReady  = (count_q < C_DEPTH);
  assign BufEmpty = (count_q == '0);
  assign enq      = StReq && StReady;

  // --------------------------------------------------------------------------
  // Pointer and occupancy update
  // --------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (enq) begin
      tail_d = tail_q + PW'(1);
    end
    if (drain) begin
      head_d = head_q + PW'(1);
    end
    case ({enq, drain})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage carries no reset: contents are qualified by count_q.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_q[tail_q] <= {StAd, StFunc3, StData};
    end
  end

endmodule : store_buffer
`default_nettype wire

// File: tb/tb_store_buffer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_store_buffer
// Purpose : Self-checking bench for store_buffer. A behavioural model keeps
//           the pending stores as a queue and the committed memory as a byte
//           array (big-endian RAM). A monitor on the falling edge checks the
//           handshake, hazard, port arbitration, write data and load data.
//           Honours STORE_FWD_EN in the same way as the design.
// Revision: 1.0 - initial release
// ============================================================================
module tb_store_buffer;

  localparam int WA    = 32;
  localparam int WD    = 32;
  localparam int DEPTH = 4;
`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk;
  logic          rst_n;
  logic          StReq, StReady, LdReq, LdStall, BufEmpty, RamWrite;
  logic [WA-1:0] StAd, LdAd, Ad;
  logic [WD-1:0] StData, LdData, DIn, DOut;
  logic [2:0]    StFunc3, LdFunc3, func3;

  store_buffer #(.WA(WA), .WD(WD), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .StReq    (StReq),
    .StReady  (StReady),
    .StAd     (StAd),
    .StFunc3  (StFunc3),
    .StData   (StData),
    .LdReq    (LdReq),
    .LdAd     (LdAd),
    .LdFunc3  (LdFunc3),
    .LdData   (LdData),
    .LdStall  (LdStall),
    .BufEmpty (BufEmpty),
    .Ad       (Ad),
    .RamWrite (RamWrite),
    .func3    (func3),
    .DIn      (DIn),
    .DOut     (DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  f3;
    logic [31:0] data;
  } st_t;

  st_t         exp_q[$];          // pending stores, oldest first
  logic [7:0]  ram  [0:511];      // environment RAM written by the DUT
  logic [7:0]  cmem [0:511];      // model of committed memory
  int          n_checks = 0;
  int          n_pass   = 0;
  bit          allow_st_ld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic int sz(input logic [2:0] f);
    case (f[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] ext(input logic [2:0] f, input logic [31:0] r);
    case (f)
      3'b000:  return {{24{r[7]}}, r[7:0]};
      3'b001:  return {{16{r[15]}}, r[15:0]};
      3'b100:  return {24'd0, r[7:0]};
      3'b101:  return {16'd0, r[15:0]};
      default: return r;
    endcase
  endfunction

  function automatic logic [7:0] init_byte(input int a);
    return 8'((a * 7 + 3) ^ 8'h5A);
  endfunction

  // Program-order view of one byte: committed memory overlaid by pending
  // stores, later stores winning.
  function automatic logic [7:0] view_byte(input int a);
    logic [7:0] v;
    v = cmem[a & 511];
    foreach (exp_q[i]) begin
      int s;
      int b;
      s = sz(exp_q[i].f3);
      b = int'(exp_q[i].addr);
      if (a >= b && a < b + s) v = 8'(exp_q[i].data >> (8 * (b + s - 1 - a)));
    end
    return v;
  endfunction

  function automatic logic [31:0] model_load(input int a, input logic [2:0] f);
    logic [31:0] raw;
    raw = '0;
    for (int o = 0; o < sz(f); o++) raw = (raw << 8) | {24'd0, view_byte(a + o)};
    return ext(f, raw);
  endfunction

  // Combinational big-endian RAM read
  always_comb begin
    logic [31:0] raw;
    raw = '0;
    for (int o = 0; o < 4; o++) begin
      if (o < sz(func3)) raw = (raw << 8) | {24'd0, ram[Ad[8:0] + 9'(o)]};
    end
    DOut = ext(func3, raw);
  end

  // --------------------------------------------------------------------------
  // Monitor / scoreboard
  // --------------------------------------------------------------------------
  initial begin : monitor
    int  stall_run;
    int  yng;
    bit  ovl, fwd, exp_stall, exp_rw;
    st_t e;
    stall_run = 0;
    for (int i = 0; i < 512; i++) begin
      ram[i]  = init_byte(i);
      cmem[i] = init_byte(i);
    end
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        stall_run = 0;
        chk("rst_bufempty", 32'(BufEmpty), 32'd1);
        chk("rst_stready",  32'(StReady),  32'd1);
        chk("rst_ramwrite", 32'(RamWrite), 32'd0);
        chk("rst_ldstall",  32'(LdStall),  32'd0);
      end else begin
        assert (!(StReq && LdReq) || allow_st_ld) else $error("store and load requested together");
        chk("st_ready",  32'(StReady),  32'(exp_q.size() < DEPTH));
        chk("buf_empty", 32'(BufEmpty), 32'(exp_q.size() == 0));

        ovl = 1'b0;
        fwd = 1'b0;
        yng = -1;
        exp_stall = 1'b0;
        if (LdReq) begin
          foreach (exp_q[i]) begin
            int sa, ea, sl, el;
            sa = int'(exp_q[i].addr);
            ea = sa + sz(exp_q[i].f3) - 1;
            sl = int'(LdAd);
            el = sl + sz(LdFunc3) - 1;
            if (sl <= ea && sa <= el) begin
              ovl = 1'b1;
              yng = i;
            end
          end
          if (yng >= 0) fwd = FWD && (exp_q[yng].addr == LdAd) && (sz(exp_q[yng].f3) == sz(LdFunc3));
          exp_stall = ovl && !fwd;
          chk("ld_stall", 32'(LdStall), 32'(exp_stall));
          if (!LdStall) chk("ld_data", LdData, model_load(int'(LdAd), LdFunc3));
          stall_run = LdStall ? stall_run + 1 : 0;
          if (LdStall) chk("stall_bound", 32'(stall_run > DEPTH + 1), 32'd0);
        end else begin
          stall_run = 0;
        end

        exp_rw = (exp_q.size() > 0) && !(LdReq && !exp_stall && !fwd);
        chk("ram_write", 32'(RamWrite), 32'(exp_rw));
        if (RamWrite) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_ad",    Ad,          e.addr);
            chk("wr_func3", 32'(func3),  32'(e.f3));
            chk("wr_din",   DIn,         e.data);
            for (int o = 0; o < sz(e.f3); o++)
              cmem[(int'(e.addr) + o) & 511] = 8'(e.data >> (8 * (sz(e.f3) - 1 - o)));
          end
          for (int o = 0; o < sz(func3); o++)
            ram[Ad[8:0] + 9'(o)] = 8'(DIn >> (8 * (sz(func3) - 1 - o)));
        end else if (LdReq) begin
          chk("ld_ad",    Ad,         LdAd);
          chk("ld_func3", 32'(func3), 32'(LdFunc3));
        end

        if (StReq && StReady) exp_q.push_back('{addr: StAd, f3: StFunc3, data: StData});
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d);
    int n;
    bit acc;
    StReq = 1'b1; StAd = a; StFunc3 = f; StData = d;
    n = 0;
    forever begin
      @(negedge clk);
      acc = StReady;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      chk("st_timeout", 32'(n > 20), 32'd0);
      if (n > 20) break;
    end
    StReq = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [2:0] f);
    int n;
    bit stl;
    LdReq = 1'b1; LdAd = a; LdFunc3 = f;
    n = 0;
    forever begin
      @(negedge clk);
      stl = LdStall;
      @(posedge clk);
      #1;
      if (!stl) break;
      n++;
      chk("ld_timeout", 32'(n > 20), 32'd0);
      if (n > 20) break;
    end
    LdReq = 1'b0;
  endtask

  initial begin : stim
    logic [31:0] last_a;
    logic [2:0]  last_f, lf;
    logic [2:0]  ld_codes [5];
    ld_codes[0] = 3'b000; ld_codes[1] = 3'b001; ld_codes[2] = 3'b010;
    ld_codes[3] = 3'b100; ld_codes[4] = 3'b101;
    rst_n = 1'b0;
    StReq = 1'b0; StAd = '0; StFunc3 = '0; StData = '0;
    LdReq = 1'b0; LdAd = '0; LdFunc3 = '0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);

    // Single word store drains on the following cycle
    do_store(32'h10, 3'b010, 32'hDEADBEEF);
    cyc(3);

    // Held load blocks the port so four stores fill the buffer
    allow_st_ld = 1'b1;
    LdReq = 1'b1; LdAd = 32'h100; LdFunc3 = 3'b010;
    do_store(32'h30, 3'b010, 32'hA0A1A2A3);
    do_store(32'h34, 3'b001, 32'h0000B4B5);
    do_store(32'h38, 3'b000, 32'h000000C8);
    do_store(32'h3C, 3'b010, 32'hD0D1D2D3);
    StReq = 1'b1; StAd = 32'h50; StFunc3 = 3'b010; StData = 32'h55555555;
    cyc(1);
    StReq = 1'b0;
    cyc(1);
    LdReq = 1'b0;
    allow_st_ld = 1'b0;
    cyc(6);

    // Partial overlap: always stalls
    do_store(32'h20, 3'b010, 32'h11223344);
    do_load(32'h22, 3'b100);
    cyc(2);

    // Exact match: forwarded when enabled, one stall otherwise
    do_store(32'h40, 3'b001, 32'h0000F0F0);
    do_load(32'h40, 3'b001);
    cyc(2);

    // Non-overlapping load with stores pending
    allow_st_ld = 1'b1;
    LdReq = 1'b1; LdAd = 32'h80; LdFunc3 = 3'b010;
    do_store(32'h10, 3'b010, 32'h01020304);
    do_store(32'h14, 3'b010, 32'h05060708);
    cyc(1);
    LdReq = 1'b0;
    allow_st_ld = 1'b0;
    cyc(4);

    // Reset with three stores queued discards them
    allow_st_ld = 1'b1;
    LdReq = 1'b1; LdAd = 32'h100; LdFunc3 = 3'b010;
    do_store(32'h00, 3'b010, 32'hCAFEF00D);
    do_store(32'h04, 3'b010, 32'hBAADC0DE);
    do_store(32'h08, 3'b001, 32'h00001234);
    LdReq = 1'b0;
    allow_st_ld = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_imm_bufempty", 32'(BufEmpty), 32'd1);
    chk("rst_imm_ramwrite", 32'(RamWrite), 32'd0);
    cyc(2);
    rst_n = 1'b1;
    cyc(5);

    // Randomised traffic, biased towards reloading the last store
    last_a = 32'h0; last_f = 3'b010;
    repeat (300) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        last_f = 3'($urandom_range(0, 2));
        last_a = 32'($urandom_range(0, 47));
        do_store(last_a, last_f, $urandom);
      end else if (r < 9) begin
        if ($urandom_range(0, 1) == 1) begin
          lf = (last_f == 3'b010) ? 3'b010 : (last_f | ($urandom_range(0, 1) == 1 ? 3'b100 : 3'b000));
          do_load(last_a, lf);
        end else begin
          do_load(32'($urandom_range(0, 47)), ld_codes[$urandom_range(0, 4)]);
        end
      end else begin
        cyc(1);
      end
    end
    cyc(DEPTH + 4);
    chk("final_empty", 32'(BufEmpty), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "time limit");
  end

endmodule : tb_store_buffer
`default_nettype wire
